keypad_scanner: RTL and testbench



---
 rtl/keypad_scanner.sv | 123 ++++++++++++
 tb/tb_keypad_scanner.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: drives one column low at a time, samples synchronized rows,
// resolves the first pressed key per full scan and commits it after debouncing.
module keypad_scanner #(
  parameter int SCAN_CYCLES    = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_value,
  output logic       key_pressed,
  output logic       key_event
);

  localparam int CNT_W = $clog2(SCAN_CYCLES);
  localparam int STB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_FULL = STB_W'(DEBOUNCE_SCANS);

  typedef struct packed {
    logic       found;
    logic [3:0] code;
  } scan_result_t;

  logic [3:0]       row_meta, row_sync;
  logic [CNT_W-1:0] cycle_cnt;
  logic [1:0]       col_idx;
  scan_result_t     acc, prev, scan;
  logic [STB_W-1:0] stable_cnt, stable_next;
  logic             commit_check;
  logic             sample, col_hit, same;
  logic [1:0]       hit_row;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_code = 4'h1;  4'h1: key_code = 4'h2;
      4'h2: key_code = 4'h3;  4'h3: key_code = 4'hA;
      4'h4: key_code = 4'h4;  4'h5: key_code = 4'h5;
      4'h6: key_code = 4'h6;  4'h7: key_code = 4'hB;
      4'h8: key_code = 4'h7;  4'h9: key_code = 4'h8;
      4'hA: key_code = 4'h9;  4'hB: key_code = 4'hC;
      4'hC: key_code = 4'h0;  4'hD: key_code = 4'hF;
      4'hE: key_code = 4'hE;  default: key_code = 4'hD;
    endcase
  endfunction

  assign col     = ~(4'b0001 << col_idx);
  assign sample  = (cycle_cnt == CNT_MAX);
  assign col_hit = |(~row_sync);

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    hit_row = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!row_sync[r]) hit_row = 2'(r);
    end
  end

  // Scan result as it stands once the current column is folded in; an earlier
  // column's key always wins over anything seen later in the same scan.
  always_comb begin
    scan.found = acc.found | col_hit;
    scan.code  = acc.found ? acc.code : key_code(hit_row, col_idx);
    if (!scan.found) scan.code = 4'h0;
    same = (scan.found == prev.found) && (!scan.found || scan.code == prev.code);
    if (!same)                    stable_next = STB_W'(1);
    else if (stable_cnt == STB_FULL) stable_next = stable_cnt;
    else                          stable_next = stable_cnt + STB_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_meta     <= 4'hF;
      row_sync     <= 4'hF;
      cycle_cnt    <= '0;
      col_idx      <= 2'd0;
      acc          <= '0;
      prev         <= '0;
      stable_cnt   <= '0;
      commit_check <= 1'b0;
      key_value    <= 4'h0;
      key_pressed  <= 1'b0;
      key_event    <= 1'b0;
    end else begin
      row_meta     <= row;
      row_sync     <= row_meta;
      key_event    <= 1'b0;
      commit_check <= 1'b0;

      if (sample) begin
        cycle_cnt <= '0;
        col_idx   <= col_idx + 2'd1;
        if (col_idx == 2'd3) begin
          acc          <= '0;
          prev         <= scan;
          stable_cnt   <= stable_next;
          commit_check <= (stable_next == STB_FULL);
        end else begin
          acc <= scan;
        end
      end else begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      end

      // Commit lands one edge after the final column sample.
      if (commit_check) begin
        if (prev.found) begin
          if (!key_pressed || prev.code != key_value) begin
            key_value   <= prev.code;
            key_pressed <= 1'b1;
            key_event   <= 1'b1;
          end
        end else begin
          key_pressed <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scan-by-scan bench: a keypad model drives rows from col, and a reference model
// built from the key map and debounce rules predicts outputs after every scan.
module tb_keypad_scanner;

  localparam int SC = 8;
  localparam int DB = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row, col, key_value;
  logic        key_pressed, key_event;
  logic [15:0] keys = '0;

  int total = 0, bad = 0, ev_cnt = 0;

  logic [3:0] km [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                          4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};
  int         hist[$];
  logic [3:0] exp_val = 4'h0;
  logic       exp_prs = 1'b0, exp_evt = 1'b0;
  int         exp_ev_total = 0;

  keypad_scanner #(.SCAN_CYCLES(SC), .DEBOUNCE_SCANS(DB)) dut (
    .clk(clk), .reset(reset), .row(row), .col(col),
    .key_value(key_value), .key_pressed(key_pressed), .key_event(key_event)
  );

  always #5 clk = ~clk;

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && col[c] === 1'b0) row[r] = 1'b0;
  end

  always @(negedge clk) if (key_event === 1'b1) ev_cnt++;

  function automatic logic [15:0] key(input int r, input int c);
    logic [15:0] k = '0;
    k[r*4+c] = 1'b1;
    return k;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // First key in column-major order, or -1 when nothing is pressed.
  function automatic int scan_result(input logic [15:0] k);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (k[r*4+c]) return int'(km[r*4+c]);
    return -1;
  endfunction

  task automatic model_scan(input logic [15:0] k);
    int  res = scan_result(k);
    bit  steady = 1'b1;
    hist.push_back(res);
    exp_evt = 1'b0;
    if (hist.size() < DB) return;
    for (int i = 1; i <= DB; i++)
      if (hist[hist.size()-i] != res) steady = 1'b0;
    if (!steady) return;
    if (res >= 0) begin
      if (!exp_prs || exp_val != res[3:0]) begin
        exp_val = res[3:0];
        exp_prs = 1'b1;
        exp_evt = 1'b1;
        exp_ev_total++;
      end
    end else begin
      exp_prs = 1'b0;
    end
  endtask

  task automatic model_reset();
    hist.delete();
    exp_val = 4'h0;
    exp_prs = 1'b0;
    exp_evt = 1'b0;
  endtask

  // One full scan: first edge is the previous scan's commit edge.
  task automatic do_scan(input logic [15:0] k);
    logic [3:0] ce;
    @(posedge clk); #1;
    check("key_value", key_value, exp_val);
    check("key_pressed", key_pressed, exp_prs);
    check("key_event", key_event, exp_evt);
    keys = k;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) #1;
      ce = ~(4'b0001 << j);
      check("col", col, ce);
      if (j == 1) check("event_count", ev_cnt, exp_ev_total);
      repeat ((j < 3) ? SC : SC - 1) @(posedge clk);
    end
    model_scan(k);
  endtask

  initial begin
    logic [15:0] prev_k, k;
    int sel;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();

    repeat (3) do_scan('0);
    repeat (12) do_scan(key(1, 2));
    repeat (2) do_scan('0);
    repeat (3) do_scan(key(3, 1));
    repeat (3) do_scan(key(0, 3) | key(2, 0));
    for (int i = 0; i < 8; i++) do_scan((i % 2 == 0) ? key(0, 0) : 16'h0);
    repeat (3) do_scan(key(0, 0));

    // Reset in the middle of a scan while a key is held.
    @(posedge clk); #1;
    check("pre_reset_pressed", key_pressed, exp_prs);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("rst_key_value", key_value, 4'h0);
    check("rst_key_pressed", key_pressed, 1'b0);
    check("rst_key_event", key_event, 1'b0);
    check("rst_col", col, 4'b1110);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    repeat (3) do_scan(key(0, 0));

    prev_k = '0;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0:       k = '0;
        4:       k = key($urandom_range(0, 3), $urandom_range(0, 3));
        5:       k = key($urandom_range(0, 3), $urandom_range(0, 3))
                   | key($urandom_range(0, 3), $urandom_range(0, 3));
        default: k = prev_k;
      endcase
      do_scan(k);
      prev_k = k;
    end
    repeat (2) do_scan('0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
